// File: rtl/axi4_stream_packet_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_stream_packet_fifo                                                    |
// | AXI4-Stream FIFO, first-word fall-through, optional store-and-forward.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi4_stream_packet_fifo #(
  parameter int N           = 1,
  parameter int I           = 1,
  parameter int D           = 1,
  parameter int U           = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     S_TVALID,
  output logic                     S_TREADY,
  input  logic [8*N-1:0]           S_TDATA,
  input  logic [N-1:0]             S_TSTRB,
  input  logic [N-1:0]             S_TKEEP,
  input  logic [I-1:0]             S_TID,
  input  logic [D-1:0]             S_TDEST,
  input  logic [U-1:0]             S_TUSER,
  input  logic                     S_TLAST,
  output logic                     M_TVALID,
  input  logic                     M_TREADY,
  output logic [8*N-1:0]           M_TDATA,
  output logic [N-1:0]             M_TSTRB,
  output logic [N-1:0]             M_TKEEP,
  output logic [I-1:0]             M_TID,
  output logic [D-1:0]             M_TDEST,
  output logic [U-1:0]             M_TUSER,
  output logic                     M_TLAST,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [$clog2(DEPTH):0]   PKT_COUNT
);

  localparam int             c_aw  = $clog2(DEPTH);
  localparam int             c_ew  = 8*N + 2*N + I + D + U + 1;
  localparam logic [c_aw:0]  c_one = 1;

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [c_aw:0]   r_pkt_count;
  logic            r_cut_through;
  logic            r_ready_en;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_allow;
  logic            w_head_last;
  logic [c_ew-1:0] w_wr_entry;
  logic [c_ew-1:0] w_head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign S_TREADY = r_ready_en && !w_full;
  assign w_push   = S_TVALID && S_TREADY;
  assign w_pop    = M_TVALID && M_TREADY;

  assign w_wr_entry = {S_TLAST, S_TUSER, S_TDEST, S_TID, S_TKEEP, S_TSTRB, S_TDATA};
  assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
  assign {M_TLAST, M_TUSER, M_TDEST, M_TID, M_TKEEP, M_TSTRB, M_TDATA} = w_head;
  assign w_head_last = w_head[c_ew-1];

  // Store-and-forward holds the head back until a whole packet is buffered,
  // unless an oversized packet has forced cut-through.
  assign w_allow  = (PACKET_MODE == 0) || (r_pkt_count != '0) || r_cut_through;
  assign M_TVALID = !w_empty && w_allow;

  assign LEVEL     = r_wr_ptr - r_rd_ptr;
  assign PKT_COUNT = r_pkt_count;

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_wr_entry;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pkt_count   <= '0;
      r_cut_through <= 1'b0;
      r_ready_en    <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      case ({w_push && S_TLAST, w_pop && w_head_last})
        2'b10:   r_pkt_count <= r_pkt_count + c_one;
        2'b01:   r_pkt_count <= r_pkt_count - c_one;
        default: r_pkt_count <= r_pkt_count;
      endcase
      if (w_pop && w_head_last) begin
        r_cut_through <= 1'b0;
      end else if (w_full && (r_pkt_count == '0)) begin
        r_cut_through <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_packet_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi4_stream_packet_fifo                                                 |
// | Scoreboard bench: three FIFO configurations driven with directed packets.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi4_stream_packet_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Index 0: cut-through DEPTH 16, 1: store-and-forward DEPTH 16, 2: store-and-forward DEPTH 4
  logic [2:0]        sv, sl, sr, si, sdst, su;
  logic [2:0]        mv, mr, ml, mi, mdst, mu;
  logic [2:0][31:0]  sd, md;
  logic [2:0][3:0]   ss, sk, ms, mk;
  logic [4:0]        lv0, pc0, lv1, pc1;
  logic [2:0]        lv2, pc2;

  for (genvar g = 0; g < 3; g++) begin : g_side
    assign ss[g]   = ~sd[g][3:0];
    assign sk[g]   = sd[g][3:0];
    assign si[g]   = sd[g][4];
    assign sdst[g] = sd[g][5];
    assign su[g]   = sd[g][6];
  end

  axi4_stream_packet_fifo #(.N(4), .DEPTH(16), .PACKET_MODE(0)) u0 (
    .ACLK(clk), .ARESETn(rst_n),
    .S_TVALID(sv[0]), .S_TREADY(sr[0]), .S_TDATA(sd[0]), .S_TSTRB(ss[0]), .S_TKEEP(sk[0]),
    .S_TID(si[0]), .S_TDEST(sdst[0]), .S_TUSER(su[0]), .S_TLAST(sl[0]),
    .M_TVALID(mv[0]), .M_TREADY(mr[0]), .M_TDATA(md[0]), .M_TSTRB(ms[0]), .M_TKEEP(mk[0]),
    .M_TID(mi[0]), .M_TDEST(mdst[0]), .M_TUSER(mu[0]), .M_TLAST(ml[0]),
    .LEVEL(lv0), .PKT_COUNT(pc0));

  axi4_stream_packet_fifo #(.N(4), .DEPTH(16), .PACKET_MODE(1)) u1 (
    .ACLK(clk), .ARESETn(rst_n),
    .S_TVALID(sv[1]), .S_TREADY(sr[1]), .S_TDATA(sd[1]), .S_TSTRB(ss[1]), .S_TKEEP(sk[1]),
    .S_TID(si[1]), .S_TDEST(sdst[1]), .S_TUSER(su[1]), .S_TLAST(sl[1]),
    .M_TVALID(mv[1]), .M_TREADY(mr[1]), .M_TDATA(md[1]), .M_TSTRB(ms[1]), .M_TKEEP(mk[1]),
    .M_TID(mi[1]), .M_TDEST(mdst[1]), .M_TUSER(mu[1]), .M_TLAST(ml[1]),
    .LEVEL(lv1), .PKT_COUNT(pc1));

  axi4_stream_packet_fifo #(.N(4), .DEPTH(4), .PACKET_MODE(1)) u2 (
    .ACLK(clk), .ARESETn(rst_n),
    .S_TVALID(sv[2]), .S_TREADY(sr[2]), .S_TDATA(sd[2]), .S_TSTRB(ss[2]), .S_TKEEP(sk[2]),
    .S_TID(si[2]), .S_TDEST(sdst[2]), .S_TUSER(su[2]), .S_TLAST(sl[2]),
    .M_TVALID(mv[2]), .M_TREADY(mr[2]), .M_TDATA(md[2]), .M_TSTRB(ms[2]), .M_TKEEP(mk[2]),
    .M_TID(mi[2]), .M_TDEST(mdst[2]), .M_TUSER(mu[2]), .M_TLAST(ml[2]),
    .LEVEL(lv2), .PKT_COUNT(pc2));

  int tests = 0;
  int fails = 0;
  logic [43:0] q0[$], q1[$], q2[$];
  logic        track = 1'b0;
  logic [4:0]  maxlv0;
  logic        pdone;

  // Sideband fields are derived from the data word so every beat is self-describing.
  function automatic logic [43:0] exp_of(input logic [31:0] d, input logic l);
    return {l, d[6], d[5], d[4], d[3:0], ~d[3:0], d};
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [43:0] e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic [43:0] act);
    logic [43:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL mon%0d: unexpected beat %h, required none", i, act);
    end else if (act !== e) begin
      fails++;
      $display("FAIL mon%0d: beat %h, required %h", i, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (track && lv0 > maxlv0) maxlv0 = lv0;
      for (int i = 0; i < 3; i++) begin
        if (mv[i] && mr[i]) mon(i, {ml[i], mu[i], mdst[i], mi[i], mk[i], ms[i], md[i]});
      end
    end
  end

  task automatic push(input int i, input logic [31:0] d, input logic l);
    bit ok;
    ok    = 1'b0;
    sv[i] = 1'b1;
    sd[i] = d;
    sl[i] = l;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sr[i]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push%0d: S_TREADY stuck at 0, required 1", i);
    end else begin
      @(posedge clk);
      push_exp(i, exp_of(d, l));
    end
    #1 sv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (qsize(i) == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain%0d: %0d beats outstanding, required 0", i, qsize(i));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sv = '0; sl = '0; mr = '0; sd = '0;
    pdone = 1'b0;
    #1;
    check("rst_sready", {29'd0, sr}, 32'd0);
    check("rst_mvalid", {29'd0, mv}, 32'd0);
    check("rst_level", {27'd0, lv0}, 32'd0);
    check("rst_pkt", {27'd0, pc0}, 32'd0);
    check("rst_mdata", md[0], 32'd0);
    #12 rst_n = 1'b1;
    #1 check("sready_pre_edge", {29'd0, sr}, 32'd0);
    @(posedge clk); #1;
    check("sready_post_edge", {29'd0, sr}, 32'd7);

    // Basic ordering with a free-running consumer
    mr[0] = 1'b1; maxlv0 = '0; track = 1'b1;
    check("lat_pre", {31'd0, mv[0]}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      push(0, k, k == 8);
      if (k == 1) check("lat_first", {31'd0, mv[0]}, 32'd1);
    end
    drain(0);
    track = 1'b0;
    check("peak_level", {27'd0, maxlv0}, 32'd1);
    check("basic_pkt", {27'd0, pc0}, 32'd0);

    // Fill, stall, single pop, refill
    mr[0] = 1'b0;
    for (int k = 1; k <= 16; k++) push(0, 32'h100 + k, k == 16);
    check("full_level", {27'd0, lv0}, 32'd16);
    check("full_sready", {31'd0, sr[0]}, 32'd0);
    sv[0] = 1'b1; sd[0] = 32'h111; sl[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_level", {27'd0, lv0}, 32'd16);
    check("stall_sready", {31'd0, sr[0]}, 32'd0);
    mr[0] = 1'b1;
    @(posedge clk); #1;
    mr[0] = 1'b0;
    check("pop1_level", {27'd0, lv0}, 32'd15);
    check("pop1_sready", {31'd0, sr[0]}, 32'd1);
    push(0, 32'h111, 1'b1);
    check("refill_level", {27'd0, lv0}, 32'd16);
    check("refill_pkt", {27'd0, pc0}, 32'd2);
    mr[0] = 1'b1;
    drain(0);
    mr[0] = 1'b0;

    // Simultaneous TLAST push and TLAST pop at LEVEL 5
    push(0, 32'h201, 1'b1);
    for (int k = 2; k <= 5; k++) push(0, 32'h200 + k, 1'b0);
    check("sim_pre_level", {27'd0, lv0}, 32'd5);
    check("sim_pre_pkt", {27'd0, pc0}, 32'd1);
    sv[0] = 1'b1; sd[0] = 32'h206; sl[0] = 1'b1; mr[0] = 1'b1;
    @(posedge clk);
    push_exp(0, exp_of(32'h206, 1'b1));
    #1 sv[0] = 1'b0; mr[0] = 1'b0;
    check("sim_level", {27'd0, lv0}, 32'd5);
    check("sim_pkt", {27'd0, pc0}, 32'd1);
    mr[0] = 1'b1;
    drain(0);
    mr[0] = 1'b0;
    check("sim_post_pkt", {27'd0, pc0}, 32'd0);

    // Store-and-forward: nothing leaves until TLAST is stored
    mr[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push(1, 32'h300 + k, 1'b0);
      check("sf_hold", {31'd0, mv[1]}, 32'd0);
    end
    push(1, 32'h304, 1'b1);
    check("sf_release", {31'd0, mv[1]}, 32'd1);
    check("sf_pkt", {27'd0, pc1}, 32'd1);
    drain(1);
    check("sf_post_pkt", {27'd0, pc1}, 32'd0);
    check("sf_post_valid", {31'd0, mv[1]}, 32'd0);

    // Oversized packet through a 4-deep store-and-forward FIFO
    mr[2] = 1'b0;
    for (int k = 1; k <= 4; k++) push(2, 32'h400 + k, 1'b0);
    check("os_level", {29'd0, lv2}, 32'd4);
    check("os_pkt", {29'd0, pc2}, 32'd0);
    @(posedge clk); #1;
    check("os_cut", {31'd0, mv[2]}, 32'd1);
    fork
      begin
        for (int k = 5; k <= 10; k++) push(2, 32'h400 + k, k == 10);
        pdone = 1'b1;
      end
      begin
        for (int t = 0; t < 1000; t++) begin
          @(posedge clk); #1;
          if (pdone && q2.size() == 0 && lv2 == 3'd0) break;
          mr[2] = 1'($urandom_range(0, 1));
        end
      end
    join
    mr[2] = 1'b0;
    check("os_drained", {29'd0, lv2}, 32'd0);
    check("os_queue", q2.size(), 32'd0);
    check("os_post_pkt", {29'd0, pc2}, 32'd0);
    push(2, 32'h40b, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("os_cut_cleared", {31'd0, mv[2]}, 32'd0);
    push(2, 32'h40c, 1'b1);
    check("os_next_pkt", {31'd0, mv[2]}, 32'd1);
    mr[2] = 1'b1;
    drain(2);
    mr[2] = 1'b0;

    // Asynchronous reset with a partial packet stored
    mr[0] = 1'b0;
    push(0, 32'h501, 1'b0);
    push(0, 32'h502, 1'b1);
    push(0, 32'h503, 1'b0);
    check("mid_level", {27'd0, lv0}, 32'd3);
    check("mid_pkt", {27'd0, pc0}, 32'd1);
    #3 rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_mvalid", {31'd0, mv[0]}, 32'd0);
    check("arst_sready", {31'd0, sr[0]}, 32'd0);
    check("arst_level", {27'd0, lv0}, 32'd0);
    check("arst_pkt", {27'd0, pc0}, 32'd0);
    check("arst_mdata", md[0], 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rel_sready_pre", {31'd0, sr[0]}, 32'd0);
    @(posedge clk); #1;
    check("rel_sready", {31'd0, sr[0]}, 32'd1);
    check("rel_mvalid", {31'd0, mv[0]}, 32'd0);
    mr[0] = 1'b1;
    push(0, 32'h601, 1'b0);
    push(0, 32'h602, 1'b1);
    drain(0);
    check("rel_pkt", {27'd0, pc0}, 32'd0);
    check("rel_level", {27'd0, lv0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
